// File: rtl/trap_filter_cfg.sv
// Run-time configurable trapezoidal shaper for one ADC channel: four-stage valid-tagged
// pipeline, output saturation, config validation and a delay line zeroed on every (re)start.
module trap_filter_cfg #(
    parameter int ADC_W     = 12,
    parameter int OUT_W     = 16,
    parameter int ACC_W     = 32,
    parameter int M_W       = 8,
    parameter int MAX_DELAY = 64,
    parameter int DEF_K     = 4,
    parameter int DEF_L     = 8,
    parameter int DEF_SHIFT = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [ADC_W-1:0]              in_data,
    output logic                          in_ready,
    input  logic                          cfg_load,
    input  logic [$clog2(MAX_DELAY):0]    cfg_k,
    input  logic [$clog2(MAX_DELAY):0]    cfg_l,
    input  logic [M_W-1:0]                cfg_m,
    input  logic [$clog2(ACC_W)-1:0]      cfg_shift,
    output logic                          cfg_err,
    output logic                          out_valid,
    output logic [OUT_W-1:0]              out_data,
    output logic                          out_sat,
    output logic                          settled
);
    localparam int AW = $clog2(MAX_DELAY);
    localparam int KW = AW + 1;
    localparam int SW = $clog2(ACC_W);
    localparam logic [AW-1:0] LAST_IDX = AW'(MAX_DELAY - 1);
    localparam logic [KW:0]   MAX_SUM  = (KW+1)'(MAX_DELAY);

    typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    // Clamp to the signed OUT_W range; MSB of the result is the saturation flag.
    function automatic logic [OUT_W:0] sat_out(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        hi = ACC_W'((32'sd1 <<< (OUT_W - 1)) - 32'sd1);
        lo = ~hi;
        if (v > hi) begin
            sat_out = {1'b1, hi[OUT_W-1:0]};
        end else if (v < lo) begin
            sat_out = {1'b1, lo[OUT_W-1:0]};
        end else begin
            sat_out = {1'b0, v[OUT_W-1:0]};
        end
    endfunction

    state_t                  state_r;
    logic [AW-1:0]           clr_idx_r;
    logic [AW-1:0]           wp_r;
    logic [KW-1:0]           k_r;
    logic [KW-1:0]           l_r;
    logic [KW-1:0]           kl_r;
    logic [M_W-1:0]          m_r;
    logic [SW-1:0]           shift_r;
    logic [KW-1:0]           cnt_r;
    logic [ADC_W-1:0]        dly_r [MAX_DELAY];

    logic                    v1_r, v2_r, v3_r;
    logic signed [ACC_W-1:0] d1_r, d2_r, d_r, p_r, r_r, s_r;

    logic                    run_s, cfg_ok_s, cfg_apply_s, cfg_rej_s, accept_s, flush_s;
    logic [KW:0]             cfg_sum_s;
    logic signed [ACC_W-1:0] x_s, xk_s, xl_s, xkl_s, d_s, m_ext_s, r_s, s_next_s, shifted_s;
    logic [OUT_W:0]          sat_s;

    // Config decode, sample acceptance, delay-line taps and per-stage arithmetic.
    always_comb begin
        run_s       = (state_r == ST_RUN);
        cfg_sum_s   = {1'b0, cfg_k} + {1'b0, cfg_l};
        cfg_ok_s    = (cfg_k >= KW'(1)) && (cfg_k <= cfg_l) && (cfg_sum_s <= MAX_SUM);
        cfg_apply_s = run_s && cfg_load && cfg_ok_s;
        cfg_rej_s   = run_s && cfg_load && !cfg_ok_s;
        accept_s    = run_s && in_valid && !cfg_apply_s;
        flush_s     = !run_s || cfg_apply_s;
        // Taps read the slot before this cycle's write, so k+l = MAX_DELAY lands on wp itself.
        x_s       = {{(ACC_W-ADC_W){1'b0}}, in_data};
        xk_s      = {{(ACC_W-ADC_W){1'b0}}, dly_r[wp_r - k_r[AW-1:0]]};
        xl_s      = {{(ACC_W-ADC_W){1'b0}}, dly_r[wp_r - l_r[AW-1:0]]};
        xkl_s     = {{(ACC_W-ADC_W){1'b0}}, dly_r[wp_r - kl_r[AW-1:0]]};
        d_s       = d1_r - d2_r;
        m_ext_s   = {{(ACC_W-M_W){1'b0}}, m_r};
        r_s       = p_r + m_ext_s * d_r;
        s_next_s  = s_r + r_r;
        shifted_s = s_next_s >>> shift_r;
        sat_s     = sat_out(shifted_s);
    end

    // Control FSM: delay-line clear sweep, config registers, settle counter, status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_CLEAR;
            clr_idx_r <= {AW{1'b0}};
            wp_r      <= {AW{1'b0}};
            k_r       <= KW'(DEF_K);
            l_r       <= KW'(DEF_L);
            kl_r      <= KW'(DEF_K + DEF_L);
            m_r       <= {M_W{1'b0}};
            shift_r   <= SW'(DEF_SHIFT);
            cnt_r     <= {KW{1'b0}};
            in_ready  <= 1'b0;
            cfg_err   <= 1'b0;
            settled   <= 1'b0;
        end else begin
            cfg_err <= cfg_rej_s;
            case (state_r)
                ST_CLEAR: begin
                    clr_idx_r <= clr_idx_r + AW'(1);
                    if (clr_idx_r == LAST_IDX) begin
                        state_r  <= ST_RUN;
                        in_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cfg_apply_s) begin
                        k_r       <= cfg_k;
                        l_r       <= cfg_l;
                        kl_r      <= cfg_sum_s[KW-1:0];
                        m_r       <= cfg_m;
                        shift_r   <= cfg_shift;
                        state_r   <= ST_CLEAR;
                        clr_idx_r <= {AW{1'b0}};
                        wp_r      <= {AW{1'b0}};
                        cnt_r     <= {KW{1'b0}};
                        in_ready  <= 1'b0;
                        settled   <= 1'b0;
                    end else if (accept_s) begin
                        wp_r    <= wp_r + AW'(1);
                        settled <= ((cnt_r + KW'(1)) >= kl_r);
                        if (cnt_r < kl_r) begin
                            cnt_r <= cnt_r + KW'(1);
                        end
                    end
                end
                default: begin
                    state_r   <= ST_CLEAR;
                    clr_idx_r <= {AW{1'b0}};
                    in_ready  <= 1'b0;
                end
            endcase
        end
    end

    // Delay-line storage: zero-filled one entry per cycle while clearing, else one write per sample.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            dly_r[clr_idx_r] <= {ADC_W{1'b0}};
        end else if (accept_s) begin
            dly_r[wp_r] <= in_data;
        end
    end

    // Four-stage shaping pipeline; accumulators move only on valid-tagged stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush_s) begin
            {v1_r, v2_r, v3_r} <= 3'b000;
            d1_r      <= {ACC_W{1'b0}};
            d2_r      <= {ACC_W{1'b0}};
            d_r       <= {ACC_W{1'b0}};
            p_r       <= {ACC_W{1'b0}};
            r_r       <= {ACC_W{1'b0}};
            s_r       <= {ACC_W{1'b0}};
            out_valid <= 1'b0;
            out_data  <= {OUT_W{1'b0}};
            out_sat   <= 1'b0;
        end else begin
            v1_r <= accept_s;
            if (accept_s) begin
                d1_r <= x_s - xk_s;
                d2_r <= xl_s - xkl_s;
            end
            v2_r <= v1_r;
            if (v1_r) begin
                d_r <= d_s;
                p_r <= p_r + d_s;
            end
            v3_r <= v2_r;
            if (v2_r) begin
                r_r <= r_s;
            end
            out_valid <= v3_r;
            if (v3_r) begin
                s_r      <= s_next_s;
                out_data <= sat_s[OUT_W-1:0];
                out_sat  <= sat_s[OUT_W];
            end
        end
    end
endmodule

// File: doc/trap_filter_cfg.md
# trap_filter_cfg

Parametrised, run-time-configurable trapezoidal shaping filter for one ADC channel. Generalises the fixed-coefficient shaper: rise time k, flat-top parameter l, pole-zero multiplier m and output shift are loaded at run time over a config handshake. The block adds input/output valid qualification, output saturation, config validation and a self-clearing delay line. Sits between the ADC capture stage and the peak/energy extraction logic.

## Interface
- ADC_W, 12, input sample width (unsigned)
- OUT_W, 16, output width (signed)
- ACC_W, 32, internal accumulator width (signed)
- M_W, 8, width of m (unsigned)
- MAX_DELAY, 64, circular delay-line depth; power of two
- DEF_K, 4, k after reset
- DEF_L, 8, l after reset
- DEF_SHIFT, 4, output right-shift after reset
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  sample strobe
- in_data  in  ADC_W  sample, zero-extended
- in_ready  out  1  high when a sample is accepted
- cfg_load  in  1  config strobe
- cfg_k, cfg_l  in  $clog2(MAX_DELAY)+1 each  new k, l
- cfg_m  in  M_W  new m
- cfg_shift  in  $clog2(ACC_W)  new shift
- cfg_err  out  1  one-cycle pulse, config rejected
- out_valid  out  1  output strobe
- out_data  out  OUT_W  filtered sample, signed
- out_sat  out  1  qualifies out_data: saturated
- settled  out  1  at least k+l samples consumed since last clear

## Operation
- Per accepted sample n: d[n]=x[n]−x[n−k]−x[n−l]+x[n−k−l]; p[n]=p[n−1]+d[n]; r[n]=p[n]+m·d[n]; s[n]=s[n−1]+r[n]; y[n]=sat_OUT_W(s[n]>>>shift).
- All internal arithmetic is signed, ACC_W bits. p and s wrap modulo 2^ACC_W, with no saturation internally. Saturation happens only at output: clamp to [−2^(OUT_W−1), 2^(OUT_W−1)−1], with out_sat=1 when clamped.
- Delay line: circular buffer of MAX_DELAY entries with write pointer wrapping at MAX_DELAY. Taps are read at (wp−j) mod MAX_DELAY.
- FSM states:
  - CLEAR: writes 0 to every delay entry, one per cycle, for MAX_DELAY cycles. Zeros p, s and valid tags. in_ready=0; in_valid and cfg_load are ignored. Goes to RUN after the last entry.
  - RUN: in_ready=1. A sample is accepted when in_valid=1.
- Config is accepted only in RUN. It is valid iff 1≤k≤l and k+l≤MAX_DELAY.
  - Valid config: k, l, m and shift registers update; in-flight samples are discarded (no out_valid); FSM goes to CLEAR.
  - Invalid config: cfg_err pulses for one cycle after the strobe; config and state are unchanged.
- cfg_load and in_valid in the same RUN cycle: the sample is consumed and discarded, and the config is applied.
- settled: counter of accepted samples saturating at k+l. Cleared on entry to CLEAR. settled=1 when count≥k+l.
- Reset (any time, including mid-pipeline): k=DEF_K, l=DEF_L, m=0, shift=DEF_SHIFT. All outputs go to 0 (in_ready=0, cfg_err=0, out_valid=0, out_data=0, out_sat=0, settled=0). FSM goes to CLEAR.

## Timing
- Pipeline is fixed length, non-stalling, with valid tags. Stage 1: tap reads and d1/d2. Stage 2: d and p. Stage 3: r. Stage 4: s, shift and saturate into registered outputs.
- Latency: out_valid asserts exactly 4 cycles after the in_valid cycle. There is one output per accepted sample, in order. Gaps in in_valid produce matching gaps in out_valid.
- Accumulators update only on valid-tagged stages.
- After reset deassertion, in_ready rises after MAX_DELAY cycles. The same applies after a valid cfg_load.
- Back-to-back samples are accepted every cycle in RUN.

## Test plan
- Reset, wait for in_ready, then a continuous stream with k=4, l=8, m=0, shift=0: 0,0,16,16,… (step of 16 at n0). Required: y = 16, 32, 48, 64 at n0..n0+3; 64 through n0+7; then 48, 32, 16, 0; 0 thereafter. Latency 4 cycles; settled rises after 12 samples.
- Impulse of 1 at n0 with k=4, l=8, m=2, shift=0. Required: y = 3, 4, 5, 6 at n0..n0+3; 4 at n0+4.
- Full-scale step of 4095 with k=32, l=32, m=0, shift=0. Required: out_data clamps at 32767 with out_sat=1, then returns to 0 with out_sat=0.
- cfg_load with k=9, l=4: cfg_err pulses once and the old config stays active. Then cfg_load with k+l=65: rejected. Then a valid k=8, l=8: in_ready=0 for 64 cycles, and pending outputs are suppressed.
- Randomised in_valid gaps plus k=l=MAX_DELAY/2 (pointer wrap): outputs match the reference equation sample-for-sample.
- Assert reset mid-stream with data in the pipeline. Required: all outputs 0 immediately, no stale out_valid, and defaults restored (a DEF_K/DEF_L step response is observed after reset).
